// File: rtl/axi_lite_master_arbiter_2to1_if.sv
// axi_lite_master_arbiter_2to1_if: requester ports and AXI4-Lite master bus of the 2:1 arbiter
interface axi_lite_master_arbiter_2to1_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);
  logic                      req0_valid, req0_ready, req0_write;
  logic [ADDR_WIDTH-1:0]     req0_addr;
  logic [DATA_WIDTH-1:0]     req0_wdata;
  logic [DATA_WIDTH/8-1:0]   req0_wstrb;
  logic                      rsp0_valid;
  logic [DATA_WIDTH-1:0]     rsp0_rdata;
  logic [1:0]                rsp0_resp;
  logic                      req1_valid, req1_ready, req1_write;
  logic [ADDR_WIDTH-1:0]     req1_addr;
  logic [DATA_WIDTH-1:0]     req1_wdata;
  logic [DATA_WIDTH/8-1:0]   req1_wstrb;
  logic                      rsp1_valid;
  logic [DATA_WIDTH-1:0]     rsp1_rdata;
  logic [1:0]                rsp1_resp;
  logic                      busy, grant;
  logic [ADDR_WIDTH-1:0]     M_AXI_AWADDR;
  logic [2:0]                M_AXI_AWPROT;
  logic                      M_AXI_AWVALID, M_AXI_AWREADY;
  logic [DATA_WIDTH-1:0]     M_AXI_WDATA;
  logic [DATA_WIDTH/8-1:0]   M_AXI_WSTRB;
  logic                      M_AXI_WVALID, M_AXI_WREADY;
  logic [1:0]                M_AXI_BRESP;
  logic                      M_AXI_BVALID, M_AXI_BREADY;
  logic [ADDR_WIDTH-1:0]     M_AXI_ARADDR;
  logic [2:0]                M_AXI_ARPROT;
  logic                      M_AXI_ARVALID, M_AXI_ARREADY;
  logic [DATA_WIDTH-1:0]     M_AXI_RDATA;
  logic [1:0]                M_AXI_RRESP;
  logic                      M_AXI_RVALID, M_AXI_RREADY;
  modport master (
    input  req0_valid, req0_write, req0_addr, req0_wdata, req0_wstrb,
    input  req1_valid, req1_write, req1_addr, req1_wdata, req1_wstrb,
    output req0_ready, rsp0_valid, rsp0_rdata, rsp0_resp,
    output req1_ready, rsp1_valid, rsp1_rdata, rsp1_resp,
    output busy, grant,
    output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID, input M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, input M_AXI_WREADY,
    input  M_AXI_BRESP, M_AXI_BVALID, output M_AXI_BREADY,
    output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID, input M_AXI_ARREADY,
    input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID, output M_AXI_RREADY
  );
  modport slave (
    output req0_valid, req0_write, req0_addr, req0_wdata, req0_wstrb,
    output req1_valid, req1_write, req1_addr, req1_wdata, req1_wstrb,
    input  req0_ready, rsp0_valid, rsp0_rdata, rsp0_resp,
    input  req1_ready, rsp1_valid, rsp1_rdata, rsp1_resp,
    input  busy, grant,
    input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID, output M_AXI_AWREADY,
    input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, output M_AXI_WREADY,
    output M_AXI_BRESP, M_AXI_BVALID, input M_AXI_BREADY,
    input  M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID, output M_AXI_ARREADY,
    output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID, input M_AXI_RREADY
  );
endinterface

// File: rtl/axi_lite_master_arbiter_2to1.sv
// axi_lite_master_arbiter_2to1: round-robin sharing of one AXI4-Lite slave between two command requesters
module axi_lite_master_arbiter_2to1 #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input logic clock,
  input logic reset,
  axi_lite_master_arbiter_2to1_if.master bus
);
  localparam int SW = DATA_WIDTH / 8;
  typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA} state_t;
  state_t                r_state;
  logic                  r_last, r_grant;
  logic                  r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
  logic [ADDR_WIDTH-1:0] r_awaddr, r_araddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [SW-1:0]         r_wstrb;
  logic [1:0]            r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata [2];
  logic [1:0]            r_rsp_resp [2];
  logic                  w_idle, w_sel, w_accept, w_write, w_aw_done, w_w_done;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [SW-1:0]         w_wstrb;
  // winner selection: a lone requester always wins, a tie goes to the one not served last
  always_comb begin
    w_idle    = r_state == IDLE;
    w_sel     = (bus.req0_valid && bus.req1_valid) ? ~r_last : bus.req1_valid;
    w_accept  = w_idle && (bus.req0_valid || bus.req1_valid);
    w_write   = w_sel ? bus.req1_write : bus.req0_write;
    w_addr    = w_sel ? bus.req1_addr : bus.req0_addr;
    w_wdata   = w_sel ? bus.req1_wdata : bus.req0_wdata;
    w_wstrb   = w_sel ? bus.req1_wstrb : bus.req0_wstrb;
    w_aw_done = !r_awvalid || bus.M_AXI_AWREADY;
    w_w_done  = !r_wvalid || bus.M_AXI_WREADY;
  end
  assign bus.req0_ready    = w_idle && bus.req0_valid && !w_sel;
  assign bus.req1_ready    = w_idle && bus.req1_valid && w_sel;
  assign bus.busy          = !w_idle;
  assign bus.grant         = r_grant;
  assign bus.rsp0_valid    = r_rsp_valid[0];
  assign bus.rsp1_valid    = r_rsp_valid[1];
  assign bus.rsp0_rdata    = r_rsp_rdata[0];
  assign bus.rsp1_rdata    = r_rsp_rdata[1];
  assign bus.rsp0_resp     = r_rsp_resp[0];
  assign bus.rsp1_resp     = r_rsp_resp[1];
  assign bus.M_AXI_AWADDR  = r_awaddr;
  assign bus.M_AXI_AWPROT  = 3'b000;
  assign bus.M_AXI_AWVALID = r_awvalid;
  assign bus.M_AXI_WDATA   = r_wdata;
  assign bus.M_AXI_WSTRB   = r_wstrb;
  assign bus.M_AXI_WVALID  = r_wvalid;
  assign bus.M_AXI_BREADY  = r_bready;
  assign bus.M_AXI_ARADDR  = r_araddr;
  assign bus.M_AXI_ARPROT  = 3'b000;
  assign bus.M_AXI_ARVALID = r_arvalid;
  assign bus.M_AXI_RREADY  = r_rready;
  // transaction sequencer: one AXI4-Lite access at a time, response routed back to the owner
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_last      <= 1'b1;
      r_grant     <= 1'b0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_awaddr    <= '0;
      r_araddr    <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '{default: '0};
      r_rsp_resp  <= '{default: '0};
    end else begin
      r_rsp_valid <= '0;
      case (r_state)
        IDLE: if (w_accept) begin
          r_last  <= w_sel;
          r_grant <= w_sel;
          if (w_write) begin
            r_awaddr  <= w_addr;
            r_wdata   <= w_wdata;
            r_wstrb   <= w_wstrb;
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_state   <= WADDR;
          end else begin
            r_araddr  <= w_addr;
            r_arvalid <= 1'b1;
            r_state   <= RADDR;
          end
        end
        WADDR: begin
          if (bus.M_AXI_AWREADY) r_awvalid <= 1'b0;
          if (bus.M_AXI_WREADY) r_wvalid <= 1'b0;
          if (w_aw_done && w_w_done) begin
            r_bready <= 1'b1;
            r_state  <= WRESP;
          end
        end
        WRESP: if (bus.M_AXI_BVALID) begin
          r_bready             <= 1'b0;
          r_rsp_valid[r_grant] <= 1'b1;
          r_rsp_rdata[r_grant] <= '0;
          r_rsp_resp[r_grant]  <= bus.M_AXI_BRESP;
          r_state              <= IDLE;
        end
        RADDR: if (bus.M_AXI_ARREADY) begin
          r_arvalid <= 1'b0;
          r_rready  <= 1'b1;
          r_state   <= RDATA;
        end
        RDATA: if (bus.M_AXI_RVALID) begin
          r_rready             <= 1'b0;
          r_rsp_valid[r_grant] <= 1'b1;
          r_rsp_rdata[r_grant] <= bus.M_AXI_RDATA;
          r_rsp_resp[r_grant]  <= bus.M_AXI_RRESP;
          r_state              <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_lite_master_arbiter_2to1.sv
// tb_axi_lite_master_arbiter_2to1: directed and randomized checks of the 2:1 AXI4-Lite arbiter
module tb_axi_lite_master_arbiter_2to1;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;
  axi_lite_master_arbiter_2to1_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus ();
  axi_lite_master_arbiter_2to1 #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (.clock(clock), .reset(reset), .bus(bus));
  typedef struct {logic wr; logic [3:0] addr; logic [31:0] wdata; logic [3:0] strb;} cmd_t;
  typedef struct {logic [31:0] rdata; logic [1:0] resp; int due;} rsp_t;
  // AXI4-Lite register file with programmable ready delays; register 0xC answers SLVERR
  logic [31:0] smem [4];
  int aw_cnt, w_cnt, ar_cnt;
  int aw_dly = 0, w_dly = 0, ar_dly = 0;
  int aw_hs = 0, w_hs = 0;
  logic aw_got, w_got, s_bvalid, s_rvalid;
  logic [3:0] aw_a, w_s, s_wa, s_ws;
  logic [31:0] w_d, s_wd, s_rdata;
  logic [1:0] s_bresp, s_rresp;
  logic aw_hsk, w_hsk, ar_hsk;
  assign bus.M_AXI_AWREADY = bus.M_AXI_AWVALID && aw_cnt >= aw_dly;
  assign bus.M_AXI_WREADY  = bus.M_AXI_WVALID && w_cnt >= w_dly;
  assign bus.M_AXI_ARREADY = bus.M_AXI_ARVALID && ar_cnt >= ar_dly;
  assign aw_hsk = bus.M_AXI_AWVALID && bus.M_AXI_AWREADY;
  assign w_hsk  = bus.M_AXI_WVALID && bus.M_AXI_WREADY;
  assign ar_hsk = bus.M_AXI_ARVALID && bus.M_AXI_ARREADY;
  assign s_wa = aw_hsk ? bus.M_AXI_AWADDR : aw_a;
  assign s_wd = w_hsk ? bus.M_AXI_WDATA : w_d;
  assign s_ws = w_hsk ? bus.M_AXI_WSTRB : w_s;
  assign bus.M_AXI_BVALID = s_bvalid;
  assign bus.M_AXI_BRESP  = s_bresp;
  assign bus.M_AXI_RVALID = s_rvalid;
  assign bus.M_AXI_RDATA  = s_rdata;
  assign bus.M_AXI_RRESP  = s_rresp;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) smem[i] <= '0;
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; s_bvalid <= 1'b0; s_rvalid <= 1'b0;
      aw_a <= '0; w_d <= '0; w_s <= '0; s_rdata <= '0; s_bresp <= '0; s_rresp <= '0;
    end else begin
      if (aw_hsk) begin
        aw_got <= 1'b1; aw_a <= bus.M_AXI_AWADDR; aw_cnt <= 0; aw_hs <= aw_hs + 1;
      end else if (bus.M_AXI_AWVALID) aw_cnt <= aw_cnt + 1;
      if (w_hsk) begin
        w_got <= 1'b1; w_d <= bus.M_AXI_WDATA; w_s <= bus.M_AXI_WSTRB; w_cnt <= 0; w_hs <= w_hs + 1;
      end else if (bus.M_AXI_WVALID) w_cnt <= w_cnt + 1;
      if ((aw_got || aw_hsk) && (w_got || w_hsk)) begin
        for (int i = 0; i < 4; i++) if (s_ws[i]) smem[s_wa[3:2]][8*i +: 8] <= s_wd[8*i +: 8];
        s_bvalid <= 1'b1;
        s_bresp  <= (s_wa[3:2] == 2'd3) ? 2'b10 : 2'b00;
        aw_got   <= 1'b0;
        w_got    <= 1'b0;
      end
      if (s_bvalid && bus.M_AXI_BREADY) s_bvalid <= 1'b0;
      if (ar_hsk) begin
        s_rvalid <= 1'b1;
        s_rdata  <= smem[bus.M_AXI_ARADDR[3:2]];
        s_rresp  <= (bus.M_AXI_ARADDR[3:2] == 2'd3) ? 2'b10 : 2'b00;
        ar_cnt   <= 0;
      end else if (bus.M_AXI_ARVALID) ar_cnt <= ar_cnt + 1;
      if (s_rvalid && bus.M_AXI_RREADY) s_rvalid <= 1'b0;
    end
  end
  cmd_t q0[$], q1[$];
  rsp_t e0[$], e1[$];
  logic [31:0] mref [4];
  logic last_ref = 1'b1, grant_ref = 1'b0;
  int grants[$];
  int cyc = 0, acc_cyc = 0, checks = 0, errors = 0, nwr = 0;
  logic [31:0] last_rdata [2];
  logic tr_aw [int], tr_w [int], tr_b [int];
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  function automatic cmd_t mk(input logic wr, input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    cmd_t c;
    c.wr = wr; c.addr = a; c.wdata = d; c.strb = s;
    return c;
  endfunction
  function automatic cmd_t rnd();
    return mk(1'($urandom_range(0, 1)), 4'($urandom_range(0, 3) * 4), $urandom, 4'($urandom_range(0, 15)));
  endfunction
  // drive both requester queues cycle by cycle, predicting grants, responses and their latency
  task automatic run_batch(input int budget, input bit stop_b);
    int n = 0;
    int lat;
    cmd_t c;
    rsp_t r;
    logic v0, v1, sel, idle;
    logic [1:0] idx;
    while ((q0.size() != 0 || q1.size() != 0 || e0.size() != 0 || e1.size() != 0) && n < budget) begin
      @(negedge clock);
      n++;
      cyc++;
      if (bus.rsp0_valid) begin
        chk("rsp0_expected", e0.size() != 0, 1);
        if (e0.size() != 0) begin
          r = e0.pop_front();
          chk("rsp0_rdata", bus.rsp0_rdata, r.rdata);
          chk("rsp0_resp", bus.rsp0_resp, r.resp);
          chk("rsp0_latency", cyc, r.due);
        end
        last_rdata[0] = bus.rsp0_rdata;
      end
      if (bus.rsp1_valid) begin
        chk("rsp1_expected", e1.size() != 0, 1);
        if (e1.size() != 0) begin
          r = e1.pop_front();
          chk("rsp1_rdata", bus.rsp1_rdata, r.rdata);
          chk("rsp1_resp", bus.rsp1_resp, r.resp);
          chk("rsp1_latency", cyc, r.due);
        end
        last_rdata[1] = bus.rsp1_rdata;
      end
      v0 = q0.size() != 0;
      v1 = q1.size() != 0;
      bus.req0_valid = v0;
      bus.req1_valid = v1;
      if (v0) begin
        bus.req0_write = q0[0].wr; bus.req0_addr = q0[0].addr; bus.req0_wdata = q0[0].wdata; bus.req0_wstrb = q0[0].strb;
      end
      if (v1) begin
        bus.req1_write = q1[0].wr; bus.req1_addr = q1[0].addr; bus.req1_wdata = q1[0].wdata; bus.req1_wstrb = q1[0].strb;
      end
      #1;
      tr_aw[cyc] = bus.M_AXI_AWVALID;
      tr_w[cyc]  = bus.M_AXI_WVALID;
      tr_b[cyc]  = bus.M_AXI_BREADY;
      if (stop_b && bus.M_AXI_BREADY) return;
      idle = e0.size() == 0 && e1.size() == 0;
      sel = (v0 && v1) ? !last_ref : v1;
      chk("req0_ready", bus.req0_ready, idle && v0 && !sel);
      chk("req1_ready", bus.req1_ready, idle && v1 && sel);
      chk("busy", bus.busy, !idle);
      chk("grant", bus.grant, grant_ref);
      chk("prot", {bus.M_AXI_AWPROT, bus.M_AXI_ARPROT}, 0);
      if (idle && (v0 || v1)) begin
        c = sel ? q1.pop_front() : q0.pop_front();
        idx = c.addr[3:2];
        r.resp = (idx == 2'd3) ? 2'b10 : 2'b00;
        if (c.wr) begin
          for (int i = 0; i < 4; i++) if (c.strb[i]) mref[idx][8*i +: 8] = c.wdata[8*i +: 8];
          r.rdata = '0;
          lat = 3 + ((aw_dly > w_dly) ? aw_dly : w_dly);
          nwr++;
        end else begin
          r.rdata = mref[idx];
          lat = 3 + ar_dly;
        end
        r.due = cyc + lat;
        if (sel) e1.push_back(r); else e0.push_back(r);
        last_ref = sel;
        grant_ref = sel;
        grants.push_back(int'(sel));
        acc_cyc = cyc;
      end
    end
    chk("batch_done", q0.size() + q1.size() + e0.size() + e1.size() == 0, 1);
  endtask
  initial begin
    int a0, w0, n0, na, nb, t;
    bus.req0_valid = 0; bus.req0_write = 0; bus.req0_addr = 0; bus.req0_wdata = 0; bus.req0_wstrb = 0;
    bus.req1_valid = 0; bus.req1_write = 0; bus.req1_addr = 0; bus.req1_wdata = 0; bus.req1_wstrb = 0;
    for (int i = 0; i < 4; i++) mref[i] = '0;
    last_rdata[0] = '0;
    last_rdata[1] = '0;
    repeat (3) @(negedge clock);
    chk("rst_ctrl", {bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY, bus.M_AXI_ARVALID, bus.M_AXI_RREADY,
                     bus.rsp0_valid, bus.rsp1_valid, bus.busy, bus.grant, bus.req0_ready, bus.req1_ready}, 0);
    chk("rst_data", |{bus.M_AXI_AWADDR, bus.M_AXI_ARADDR, bus.M_AXI_WDATA, bus.M_AXI_WSTRB, bus.rsp0_rdata,
                      bus.rsp1_rdata, bus.rsp0_resp, bus.rsp1_resp, bus.M_AXI_AWPROT, bus.M_AXI_ARPROT}, 0);
    reset = 1'b0;
    a0 = aw_hs; w0 = w_hs;
    q0.push_back(mk(1'b1, 4'h0, 32'hDEADBEEF, 4'hF));
    q0.push_back(mk(1'b0, 4'h0, 32'h0, 4'h0));
    run_batch(100, 1'b0);
    chk("wr_rd_data", last_rdata[0], 32'hDEADBEEF);
    chk("wr_aw_once", aw_hs - a0, 1);
    chk("wr_w_once", w_hs - w0, 1);
    q1.push_back(mk(1'b1, 4'h8, 32'hABCDEF01, 4'hF));
    q1.push_back(mk(1'b1, 4'h8, 32'h0000FFFF, 4'h6));
    q1.push_back(mk(1'b0, 4'h8, 32'h0, 4'h0));
    run_batch(100, 1'b0);
    chk("strb_data", last_rdata[1], 32'hAB00FF01);
    grants.delete();
    q0.push_back(mk(1'b1, 4'h4, 32'h12345678, 4'hF));
    q1.push_back(mk(1'b0, 4'h4, 32'h0, 4'h0));
    run_batch(100, 1'b0);
    chk("tie_count", grants.size(), 2);
    chk("tie_first", grants[0], 0);
    chk("tie_read", last_rdata[1], 32'h12345678);
    grants.delete();
    repeat (2) begin
      q0.push_back(rnd());
      q1.push_back(rnd());
    end
    run_batch(200, 1'b0);
    chk("fair_count", grants.size(), 4);
    for (int i = 0; i < grants.size(); i++) chk("fair_order", grants[i], i % 2);
    aw_dly = 3; w_dly = 0;
    a0 = aw_hs; w0 = w_hs;
    q0.push_back(mk(1'b1, 4'hC, 32'hCAFEF00D, 4'hF));
    run_batch(100, 1'b0);
    t = acc_cyc;
    chk("skew_w_up", tr_w[t+1], 1);
    chk("skew_w_drop", tr_w[t+2], 0);
    chk("skew_aw_held", {tr_aw[t+1], tr_aw[t+2], tr_aw[t+3], tr_aw[t+4]}, 4'hF);
    chk("skew_aw_drop", tr_aw[t+5], 0);
    chk("skew_b_wait", tr_b[t+4], 0);
    chk("skew_b_up", tr_b[t+5], 1);
    chk("skew_aw_once", aw_hs - a0, 1);
    chk("skew_w_once", w_hs - w0, 1);
    for (int b = 0; b < 25; b++) begin
      aw_dly = $urandom_range(0, 3);
      w_dly = $urandom_range(0, 3);
      ar_dly = $urandom_range(0, 3);
      a0 = aw_hs; w0 = w_hs; n0 = nwr;
      na = $urandom_range(0, 4);
      nb = $urandom_range(0, 4);
      for (int i = 0; i < na; i++) q0.push_back(rnd());
      for (int i = 0; i < nb; i++) q1.push_back(rnd());
      run_batch(600, 1'b0);
      chk("rand_aw_count", aw_hs - a0, nwr - n0);
      chk("rand_w_count", w_hs - w0, nwr - n0);
    end
    aw_dly = 0; w_dly = 0; ar_dly = 0;
    q0.push_back(mk(1'b1, 4'h0, 32'h55AA55AA, 4'hF));
    run_batch(50, 1'b1);
    chk("wresp_reached", bus.M_AXI_BREADY, 1);
    reset = 1'b1;
    #1;
    chk("rst_axi_drop", {bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY, bus.M_AXI_ARVALID, bus.M_AXI_RREADY}, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_no_rsp", {bus.rsp0_valid, bus.rsp1_valid}, 0);
    q0.delete(); q1.delete(); e0.delete(); e1.delete();
    for (int i = 0; i < 4; i++) mref[i] = '0;
    last_ref = 1'b1;
    grant_ref = 1'b0;
    bus.req0_valid = 0;
    bus.req1_valid = 0;
    repeat (3) begin
      @(negedge clock);
      chk("rst_hold_rsp", {bus.rsp0_valid, bus.rsp1_valid}, 0);
    end
    reset = 1'b0;
    last_rdata[0] = '1;
    q0.push_back(mk(1'b0, 4'h0, 32'h0, 4'h0));
    run_batch(100, 1'b0);
    chk("post_rst_read", last_rdata[0], 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi_lite_master_arbiter_2to1.md
# axi_lite_master_arbiter_2to1

Two-requester AXI4-Lite master that shares a single AXI4-Lite slave register file (e.g. `axi_lite_slave_mmap_4x32_r4`) between two internal agents, such as the UART command bridge and the debugger core. Each requester issues single read or write commands over a simple valid/ready request port. The block arbitrates round-robin, runs exactly one AXI4-Lite transaction at a time, and returns the response to the requester that issued it.

## Interface

Parameters:
- `ADDR_WIDTH`, default 4: AXI address width.
- `DATA_WIDTH`, default 32: AXI data width, a multiple of 8.

Ports (N ∈ {0,1}, one set per requester):
- `clock`  in  1  single clock, all logic on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `reqN_valid`  in  1  command valid; held until accepted
- `reqN_ready`  out  1  command accepted when high with `reqN_valid`
- `reqN_write`  in  1  1 = write, 0 = read
- `reqN_addr`  in  ADDR_WIDTH  byte address
- `reqN_wdata`  in  DATA_WIDTH  write data
- `reqN_wstrb`  in  DATA_WIDTH/8  write byte strobes
- `rspN_valid`  out  1  one-cycle response pulse; no back-pressure
- `rspN_rdata`  out  DATA_WIDTH  read data; 0 for writes
- `rspN_resp`  out  2  BRESP or RRESP, passed through unchanged
- `busy`  out  1  high in any state other than IDLE
- `grant`  out  1  index of the requester owning the current or last transaction
- `M_AXI_AWADDR`  out  ADDR_WIDTH, `M_AXI_AWPROT`  out  3, `M_AXI_AWVALID`  out  1, `M_AXI_AWREADY`  in  1
- `M_AXI_WDATA`  out  DATA_WIDTH, `M_AXI_WSTRB`  out  DATA_WIDTH/8, `M_AXI_WVALID`  out  1, `M_AXI_WREADY`  in  1
- `M_AXI_BRESP`  in  2, `M_AXI_BVALID`  in  1, `M_AXI_BREADY`  out  1
- `M_AXI_ARADDR`  out  ADDR_WIDTH, `M_AXI_ARPROT`  out  3, `M_AXI_ARVALID`  out  1, `M_AXI_ARREADY`  in  1
- `M_AXI_RDATA`  in  DATA_WIDTH, `M_AXI_RRESP`  in  2, `M_AXI_RVALID`  in  1, `M_AXI_RREADY`  out  1

## Operation

- **States:** IDLE, WADDR, WRESP, RADDR, RDATA.
- **IDLE arbitration:**
  - Selected requester = the one with valid high. If both are valid, select the one ≠ `last_grant`.
  - `reqN_ready` = (state==IDLE) && `reqN_valid` && selected==N, combinational.
  - On acceptance, latch write/addr/wdata/wstrb and N, set `last_grant`=N, then go to WADDR (write) or RADDR (read).
- **WADDR:**
  - AWVALID and WVALID are both asserted.
  - Each channel deasserts independently after its own handshake (`aw_done`/`w_done` flags). Each is handshaked exactly once, in either order or together.
  - When both are done, go to WRESP.
- **WRESP:** BREADY=1. On BVALID, capture BRESP, pulse `rspN_valid` with rdata=0, go to IDLE.
- **RADDR:** ARVALID=1 until ARREADY, then go to RDATA.
- **RDATA:** RREADY=1. On RVALID, capture RDATA/RRESP, pulse `rspN_valid`, go to IDLE.
- **Constant and held outputs:**
  - AWPROT and ARPROT are always 3'b000.
  - Address, data and strobe outputs hold their latched values while not valid.
- **Requester rules:** a requester must not change command fields while valid and not ready. Fields are sampled only at acceptance.
- **Error responses:** SLVERR/DECERR are returned as received. The block takes no other action on them.

## Timing

- **Reset values:**
  - state=IDLE, `last_grant`=1 (req0 wins the first tie), `grant`=0.
  - All AXI valid/ready outputs, `rspN_valid`, `rspN_rdata`, `rspN_resp`, `busy`, and the address/data/strobe outputs are 0.
- **Cycle-level sequence:**
  - Acceptance cycle T.
  - AW/W (or AR) valid is registered high from T+1.
  - `rspN_valid` is high for exactly one cycle, the cycle after the B/R handshake. The state is IDLE in that same cycle, so a new command can be accepted in the response cycle.
- **Minimum latencies** (slave ready immediately, response one cycle later): write accept T → rsp T+3; read accept T → rsp T+3.
- **Throughput:** at most one transaction outstanding. Back-to-back throughput is slave-limited.
- **Reset mid-transaction:**
  - Immediately forces IDLE and drops all AXI valid/ready outputs.
  - No response pulse is generated; the transaction is lost.
  - The slave shares the same reset.
- **Single requester:** a lone requester is granted every time, regardless of `last_grant`.

## Test plan

- **Reset:** after reset, all outputs are 0. With `req0_valid`=1, `req0_ready` goes high in the first IDLE cycle.
- **Write then read:** req0 writes 0x0 / 0xDEADBEEF, strb 0xF → single AW and W handshake, `rsp0_valid` pulse with resp 00. Then req0 reads 0x0 → `rsp0_rdata`=0xDEADBEEF, resp 00.
- **Tie and fairness:** req0 (write 0x4 / 0x12345678) and req1 (read 0x4) both valid in the same cycle → req0 granted first, then req1 reads 0x12345678. With both held valid for 4 commands → grant order 0,1,0,1. `rsp1_valid` never pulses for req0's command.
- **Skewed handshake:** slave AWREADY delayed 3 cycles, WREADY immediate → WVALID drops after 1 cycle, AWVALID is held until its handshake. Exactly one of each, and BREADY rises only after both.
- **Byte strobes:** reg 0x8 holds 0xABCDEF01; req1 writes 0x0000FFFF with strb 0x6 → read of 0x8 returns 0xAB00FF01.
- **Reset during WRESP:**
  - Assert reset while BREADY=1 → all AXI valid/ready outputs are 0 in the same cycle, and no `rsp0_valid` pulse occurs.
  - After release, req0 reads 0x0 → returns 0x00000000.
